// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: accepts AW/W/B and AR/R bursts (INCR/FIXED, up to 256 beats)
// and backs them with a local byte-strobed 64-bit memory. Write and read paths are independent.
// Optional feature macro: AXI_RESP_RANGE_CHK_EN. When it is defined, beats outside
// [BASE_ADDR, BASE_ADDR+MEM_BYTES) get DECERR. Otherwise addresses wrap modulo MEM_BYTES.
module axi_mem_responder #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 64,
    parameter int unsigned          ID_W      = 4,
    parameter int unsigned          MEM_BYTES = 8192,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 32'h00000000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   S_AWID,
    input  logic [ADDR_W-1:0] S_AWADDR,
    input  logic [7:0]        S_AWLEN,
    input  logic [2:0]        S_AWSIZE,
    input  logic [1:0]        S_AWBURST,
    input  logic              S_AWVALID,
    output logic              S_AWREADY,
    input  logic [DATA_W-1:0] S_WDATA,
    input  logic [7:0]        S_WSTRB,
    input  logic              S_WLAST,
    input  logic              S_WVALID,
    output logic              S_WREADY,
    output logic [ID_W-1:0]   S_BID,
    output logic [1:0]        S_BRESP,
    output logic              S_BVALID,
    input  logic              S_BREADY,
    input  logic [ID_W-1:0]   S_ARID,
    input  logic [ADDR_W-1:0] S_ARADDR,
    input  logic [7:0]        S_ARLEN,
    input  logic [2:0]        S_ARSIZE,
    input  logic [1:0]        S_ARBURST,
    input  logic              S_ARVALID,
    output logic              S_ARREADY,
    output logic [ID_W-1:0]   S_RID,
    output logic [DATA_W-1:0] S_RDATA,
    output logic [1:0]        S_RRESP,
    output logic              S_RLAST,
    output logic              S_RVALID,
    input  logic              S_RREADY
);

    localparam int unsigned WORDS = MEM_BYTES / 8;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

`ifdef AXI_RESP_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_t;
    typedef enum logic       {RdIdle, RdData}         rd_state_t;

    logic [DATA_W-1:0] mem [WORDS];

    // Word index of a byte address; the subtraction wraps modulo 2^ADDR_W.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return (WORDS > 1) ? IDX_W'((a - BASE_ADDR) >> 3) : '0;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return !RANGE_CHK || ((a - BASE_ADDR) < ADDR_W'(MEM_BYTES));
    endfunction

    // FIXED holds the address; INCR and the reserved encodings advance by the beat size.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
    endfunction

    wr_state_t         wr_state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q, wr_beat_q;
    logic [2:0]        wr_size_q;
    logic [1:0]        wr_burst_q;

    rd_state_t         rd_state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_len_q, rd_beat_q;
    logic [2:0]        rd_size_q;
    logic [1:0]        rd_burst_q;

    logic              wr_fire, wr_ok, wr_last_beat;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] rd_next;
    logic [DATA_W-1:0] ar_word, rn_word;
    logic              ar_ok, rn_ok;

    assign wr_fire      = S_WVALID && S_WREADY;
    assign wr_ok        = in_range(wr_addr_q);
    assign wr_idx       = word_idx(wr_addr_q);
    assign wr_last_beat = (wr_beat_q == wr_len_q);
    assign rd_next      = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
    assign ar_word      = mem[word_idx(S_ARADDR)];
    assign rn_word      = mem[word_idx(rd_next)];
    assign ar_ok        = in_range(S_ARADDR);
    assign rn_ok        = in_range(rd_next);

    // Byte-lane memory write; contents are deliberately not reset.
    always_ff @(posedge ACLK) begin
        if (wr_fire && wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (S_WSTRB[i]) mem[wr_idx][8*i +: 8] <= S_WDATA[8*i +: 8];
            end
        end
    end

    // Write FSM: accept AW, absorb beats until the count reaches len, then hold B.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WrIdle;
            S_AWREADY  <= 1'b0;
            S_WREADY   <= 1'b0;
            S_BVALID   <= 1'b0;
            S_BID      <= '0;
            S_BRESP    <= RESP_OKAY;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
        end else begin
            unique case (wr_state_q)
                WrIdle: begin
                    S_AWREADY <= 1'b1;
                    if (S_AWVALID && S_AWREADY) begin
                        wr_addr_q  <= S_AWADDR;
                        wr_len_q   <= S_AWLEN;
                        wr_size_q  <= S_AWSIZE;
                        wr_burst_q <= S_AWBURST;
                        wr_beat_q  <= '0;
                        S_BID      <= S_AWID;
                        S_BRESP    <= RESP_OKAY;
                        S_AWREADY  <= 1'b0;
                        S_WREADY   <= 1'b1;
                        wr_state_q <= WrData;
                    end
                end
                WrData: begin
                    if (wr_fire) begin
                        // DECERR sticks; SLVERR never downgrades it.
                        if (!wr_ok) begin
                            S_BRESP <= RESP_DECERR;
                        end else if ((S_WLAST != wr_last_beat) && (S_BRESP != RESP_DECERR)) begin
                            S_BRESP <= RESP_SLVERR;
                        end
                        wr_addr_q <= next_addr(wr_addr_q, wr_size_q, wr_burst_q);
                        wr_beat_q <= wr_beat_q + 8'd1;
                        if (wr_last_beat) begin
                            S_WREADY   <= 1'b0;
                            S_BVALID   <= 1'b1;
                            wr_state_q <= WrResp;
                        end
                    end
                end
                WrResp: begin
                    if (S_BREADY) begin
                        S_BVALID   <= 1'b0;
                        S_AWREADY  <= 1'b1;
                        wr_state_q <= WrIdle;
                    end
                end
                default: wr_state_q <= WrIdle;
            endcase
        end
    end

    // Read FSM: registered beats, next beat fetched on each handshake so there is no bubble.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RdIdle;
            S_ARREADY  <= 1'b0;
            S_RVALID   <= 1'b0;
            S_RLAST    <= 1'b0;
            S_RID      <= '0;
            S_RDATA    <= '0;
            S_RRESP    <= RESP_OKAY;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
        end else begin
            unique case (rd_state_q)
                RdIdle: begin
                    S_ARREADY <= 1'b1;
                    if (S_ARVALID && S_ARREADY) begin
                        rd_addr_q  <= S_ARADDR;
                        rd_len_q   <= S_ARLEN;
                        rd_size_q  <= S_ARSIZE;
                        rd_burst_q <= S_ARBURST;
                        rd_beat_q  <= '0;
                        S_RID      <= S_ARID;
                        S_ARREADY  <= 1'b0;
                        S_RVALID   <= 1'b1;
                        S_RLAST    <= (S_ARLEN == 8'd0);
                        S_RDATA    <= ar_ok ? ar_word : '0;
                        S_RRESP    <= ar_ok ? RESP_OKAY : RESP_DECERR;
                        rd_state_q <= RdData;
                    end
                end
                RdData: begin
                    if (S_RVALID && S_RREADY) begin
                        if (S_RLAST) begin
                            S_RVALID   <= 1'b0;
                            S_RLAST    <= 1'b0;
                            S_ARREADY  <= 1'b1;
                            rd_state_q <= RdIdle;
                        end else begin
                            rd_addr_q <= rd_next;
                            rd_beat_q <= rd_beat_q + 8'd1;
                            S_RLAST   <= ((rd_beat_q + 8'd1) == rd_len_q);
                            S_RDATA   <= rn_ok ? rn_word : '0;
                            S_RRESP   <= rn_ok ? RESP_OKAY : RESP_DECERR;
                        end
                    end
                end
                default: rd_state_q <= RdIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: a byte-level memory model predicts every B and R beat, a
// negedge process compares the DUT against it, and directed tests pin literal values.
module tb_axi_mem_responder;

    localparam int unsigned MEM_BYTES = 8192;
    localparam logic [31:0] BASE      = 32'h00000000;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AWID, S_ARID, S_BID, S_RID;
    logic [31:0] S_AWADDR, S_ARADDR;
    logic [7:0]  S_AWLEN, S_ARLEN, S_WSTRB;
    logic [2:0]  S_AWSIZE, S_ARSIZE;
    logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
    logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
    logic [63:0] S_WDATA, S_RDATA;

    axi_mem_responder #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
        .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
        .S_BREADY(S_BREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mb [MEM_BYTES];
    bit         kn [MEM_BYTES];

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        bit          known;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t r_q[$];
    bexp_t b_q[$];

    bit          w_act;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    int          w_len, w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    bit          w_slv, w_dec;

    function automatic bit m_inr(input logic [31:0] a);
`ifdef AXI_RESP_RANGE_CHK_EN
        return (a - BASE) < MEM_BYTES;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int m_base(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) & (MEM_BYTES - 1);
        return int'(off & ~32'd7);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    function automatic logic [63:0] model_word(input logic [31:0] a);
        logic [63:0] w;
        int b;
        b = m_base(a);
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mb[b + i];
        return w;
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        bit k;
        int b;
        k = 1'b1;
        b = m_base(a);
        for (int i = 0; i < 8; i++) k = k && kn[b + i];
        return k;
    endfunction

    // Compare DUT outputs against the model, then advance the model with this cycle's inputs.
    always @(negedge ACLK) begin
        if (ARESET) begin
            check64("reset_ctrl", 64'({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID,
                                       S_RLAST}), 64'd0);
            r_q.delete();
            b_q.delete();
            w_act = 1'b0;
        end else begin
            if (S_BVALID) begin
                if (b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got BID %h BRESP %b required no response",
                             S_BID, S_BRESP);
                end else begin
                    check64("bid", 64'(S_BID), 64'(b_q[0].id));
                    check64("bresp", 64'(S_BRESP), 64'(b_q[0].resp));
                    if (S_BREADY) void'(b_q.pop_front());
                end
            end
            if (S_RVALID) begin
                if (r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got RDATA %h required no beat", S_RDATA);
                end else begin
                    check64("rid", 64'(S_RID), 64'(r_q[0].id));
                    check64("rresp", 64'(S_RRESP), 64'(r_q[0].resp));
                    check64("rlast", 64'(S_RLAST), 64'(r_q[0].last));
                    if (r_q[0].known) check64("rdata", S_RDATA, r_q[0].data);
                    if (S_RREADY) void'(r_q.pop_front());
                end
            end
            // Reads see memory before a same-cycle write lands.
            if (S_ARVALID && S_ARREADY) begin
                logic [31:0] a;
                a = S_ARADDR;
                for (int k = 0; k <= int'(S_ARLEN); k++) begin
                    rexp_t e;
                    e.id   = S_ARID;
                    e.last = (k == int'(S_ARLEN));
                    if (m_inr(a)) begin
                        e.data = model_word(a); e.known = model_known(a); e.resp = 2'b00;
                    end else begin
                        e.data = '0; e.known = 1'b1; e.resp = 2'b11;
                    end
                    r_q.push_back(e);
                    a = m_next(a, S_ARSIZE, S_ARBURST);
                end
            end
            if (S_AWVALID && S_AWREADY) begin
                w_act = 1'b1; w_id = S_AWID; w_addr = S_AWADDR; w_len = int'(S_AWLEN);
                w_size = S_AWSIZE; w_burst = S_AWBURST; w_beat = 0; w_slv = 0; w_dec = 0;
            end else if (S_WVALID && S_WREADY && w_act) begin
                if (m_inr(w_addr)) begin
                    int b;
                    b = m_base(w_addr);
                    for (int i = 0; i < 8; i++) begin
                        if (S_WSTRB[i]) begin
                            mb[b + i] = S_WDATA[8*i +: 8];
                            kn[b + i] = 1'b1;
                        end
                    end
                end else begin
                    w_dec = 1'b1;
                end
                if (S_WLAST != (w_beat == w_len)) w_slv = 1'b1;
                if (w_beat == w_len) begin
                    bexp_t be;
                    be.id   = w_id;
                    be.resp = w_dec ? 2'b11 : (w_slv ? 2'b10 : 2'b00);
                    b_q.push_back(be);
                    w_act = 1'b0;
                end
                w_beat++;
                w_addr = m_next(w_addr, w_size, w_burst);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_ready(input string name, input int which);
        int n;
        logic r;
        n = 0;
        r = (which == 0) ? S_AWREADY : (which == 1) ? S_WREADY : S_ARREADY;
        while (!r && n < 50) begin
            tick();
            n++;
            r = (which == 0) ? S_AWREADY : (which == 1) ? S_WREADY : S_ARREADY;
        end
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL %s: got ready 0 after %0d cycles required 1", name, n);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = 3'd3; S_AWBURST = 2'b01;
        S_AWVALID = 1'b1;
        wait_ready("aw_timeout", 0);
        tick();
        S_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        S_WDATA = data; S_WSTRB = strb; S_WLAST = last; S_WVALID = 1'b1;
        wait_ready("w_timeout", 1);
        tick();
        S_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = 3'd3; S_ARBURST = 2'b01;
        S_ARVALID = 1'b1;
        wait_ready("ar_timeout", 2);
        tick();
        S_ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        S_BREADY = 1'b1;
        while (S_BVALID && n < 20) begin
            tick();
            n++;
        end
        check64("b_drain", 64'(S_BVALID), 64'd0);
    endtask

    task automatic write1(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        send_aw(4'h0, addr, 8'd0);
        send_w(data, strb, 1'b1);
        wait_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [63:0] got [4];
        logic [3:0]  lasts;
        int          nb;

        ARESET = 1'b1;
        S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = 0; S_WVALID = 0; S_BREADY = 1'b1;
        S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 0;
        S_RREADY = 1'b1;
        tick(); tick(); tick();
        check64("reset_ids_resps", 64'({S_BID, S_BRESP, S_RID, S_RRESP}), 64'd0);
        check64("reset_rdata", S_RDATA, 64'd0);
        ARESET = 1'b0;

        // 1: single write with a held B, then single read
        S_BREADY = 1'b0;
        send_aw(4'h3, 32'h1000, 8'd0);
        send_w(64'hFACECAFEDEADBEEF, 8'hFF, 1'b1);
        check64("t1_bvalid_latency", 64'(S_BVALID), 64'd1);
        check64("t1_bid", 64'(S_BID), 64'h3);
        check64("t1_bresp", 64'(S_BRESP), 64'd0);
        tick();
        check64("t1_bvalid_hold", 64'(S_BVALID), 64'd1);
        S_BREADY = 1'b1;
        tick();
        check64("t1_bvalid_drop", 64'(S_BVALID), 64'd0);
        check64("t1_model_word", model_word(32'h1000), 64'hFACECAFEDEADBEEF);
        send_ar(4'h5, 32'h1000, 8'd0);
        check64("t1_rvalid_latency", 64'(S_RVALID), 64'd1);
        check64("t1_rdata", S_RDATA, 64'hFACECAFEDEADBEEF);
        check64("t1_rlast", 64'(S_RLAST), 64'd1);
        check64("t1_rid", 64'(S_RID), 64'h5);
        tick();
        check64("t1_rvalid_end", 64'(S_RVALID), 64'd0);

        // 2: INCR len3 write, readback with RREADY toggling
        send_aw(4'h1, 32'h200, 8'd3);
        for (int i = 0; i < 4; i++) send_w(64'((i + 1) * 16), 8'hFF, i == 3);
        wait_b();
        check64("t2_model_word3", model_word(32'h218), 64'h40);
        S_RREADY = 1'b0;
        send_ar(4'h2, 32'h200, 8'd3);
        nb = 0;
        lasts = '0;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            S_RREADY = c[0];
            if (S_RVALID && S_RREADY) begin
                got[nb] = S_RDATA;
                lasts[nb] = S_RLAST;
                nb++;
            end
            tick();
        end
        S_RREADY = 1'b1;
        check64("t2_beat_count", 64'(nb), 64'd4);
        for (int i = 0; i < 4; i++) check64("t2_rdata", got[i], 64'((i + 1) * 16));
        check64("t2_rlast_pattern", 64'(lasts), 64'b1000);

        // 3: partial strobe over all-ones word
        write1(32'h300, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        write1(32'h300, 64'h1122334455667788, 8'h0F);
        send_ar(4'h0, 32'h300, 8'd0);
        check64("t3_rdata", S_RDATA, 64'hFFFFFFFF55667788);
        tick();

        // 4: early WLAST on a len1 burst
        send_aw(4'h7, 32'h400, 8'd1);
        send_w(64'hA1, 8'hFF, 1'b1);
        send_w(64'hA2, 8'hFF, 1'b1);
        check64("t4_bresp", 64'(S_BRESP), 64'h2);
        check64("t4_bid", 64'(S_BID), 64'h7);
        wait_b();
        send_ar(4'h0, 32'h400, 8'd1);
        check64("t4_beat0", S_RDATA, 64'hA1);
        check64("t4_beat0_last", 64'(S_RLAST), 64'd0);
        tick();
        check64("t4_beat1", S_RDATA, 64'hA2);
        check64("t4_beat1_last", 64'(S_RLAST), 64'd1);
        tick();

        // 5: same-cycle write and read of one word
        write1(32'h500, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        send_aw(4'h9, 32'h500, 8'd0);
        check64("t5_both_ready", 64'({S_WREADY, S_ARREADY}), 64'b11);
        S_WDATA = 64'hBBBBBBBBBBBBBBBB; S_WSTRB = 8'hFF; S_WLAST = 1'b1; S_WVALID = 1'b1;
        S_ARID = 4'h4; S_ARADDR = 32'h500; S_ARLEN = 8'd0; S_ARSIZE = 3'd3; S_ARBURST = 2'b01;
        S_ARVALID = 1'b1;
        tick();
        S_WVALID = 1'b0;
        S_ARVALID = 1'b0;
        check64("t5_old_data", S_RDATA, 64'hAAAAAAAAAAAAAAAA);
        tick();
        wait_b();
        send_ar(4'h4, 32'h500, 8'd0);
        check64("t5_new_data", S_RDATA, 64'hBBBBBBBBBBBBBBBB);
        tick();

        // 6: reset in the middle of a stalled 4-beat read
        S_RREADY = 1'b0;
        send_ar(4'h6, 32'h200, 8'd3);
        check64("t6_first_beat", S_RDATA, 64'h10);
        tick();
        #2 ARESET = 1'b1;
        #1;
        check64("t6_rvalid_async", 64'(S_RVALID), 64'd0);
        check64("t6_rdata_cleared", S_RDATA, 64'd0);
        tick();
        tick();
        ARESET = 1'b0;
        S_RREADY = 1'b1;
        send_ar(4'hA, 32'h1000, 8'd0);
        check64("t6_after_reset", S_RDATA, 64'hFACECAFEDEADBEEF);
        check64("t6_after_reset_id", 64'(S_RID), 64'hA);
        tick();

`ifdef AXI_RESP_RANGE_CHK_EN
        send_ar(4'h1, BASE + MEM_BYTES, 8'd0);
        check64("t6_oor_rresp", 64'(S_RRESP), 64'h3);
        check64("t6_oor_rdata", S_RDATA, 64'd0);
        tick();
        send_aw(4'h2, BASE + MEM_BYTES + 32'd8, 8'd0);
        send_w(64'h1234, 8'hFF, 1'b0);
        check64("t6_oor_bresp", 64'(S_BRESP), 64'h3);
        wait_b();
`endif

        tick(); tick(); tick();
        check64("r_queue_drained", 64'(r_q.size()), 64'd0);
        check64("b_queue_drained", 64'(b_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
